// File: rtl/vx_ctrl_pkg.sv
// Shared definitions for the Vortex control-bus master: op encoding, FSM states
// and generic-bus widths.
package vx_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_POLL    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR       = 3'd2,
    ST_POLL_RD  = 3'd3,
    ST_POLL_GAP = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

endpackage

// File: rtl/vx_ctrl_bus_master_poll_timer.sv
// Poll pacing for vx_ctrl_bus_master: gap down-counter and, when
// VX_CTRL_MASTER_TIMEOUT_EN is defined, the poll attempt counter.
module vx_ctrl_bus_master_poll_timer #(
  parameter int POLL_INTERVAL = 4,
  parameter int MAX_POLLS     = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic gap_load,
  input  logic gap_run,
  input  logic attempt_inc,
  output logic gap_done,
  output logic timeout_hit
);

  localparam int GAP_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  // Loaded with INTERVAL-1 so the gap state lasts exactly INTERVAL cycles.
  localparam logic [GAP_W-1:0] GAP_INIT =
    (POLL_INTERVAL > 0) ? GAP_W'(POLL_INTERVAL - 1) : '0;

  logic [GAP_W-1:0] gap_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_q <= '0;
    end else if (gap_load) begin
      gap_q <= GAP_INIT;
    end else if (gap_run && (gap_q != '0)) begin
      gap_q <= gap_q - GAP_W'(1);
    end
  end

  assign gap_done = (gap_q == '0);

`ifdef VX_CTRL_MASTER_TIMEOUT_EN
  localparam int AW = $clog2(MAX_POLLS + 1);

  logic [AW-1:0] attempt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      attempt_q <= '0;
    end else if (start) begin
      attempt_q <= '0;
    end else if (attempt_inc) begin
      attempt_q <= attempt_q + AW'(1);
    end
  end

  // Qualifies the completing read: this read is attempt number MAX_POLLS.
  assign timeout_hit = (attempt_q == AW'(MAX_POLLS - 1));
`else
  localparam int unused_max_polls = MAX_POLLS;
  logic unused_attempt_inputs;
  assign unused_attempt_inputs = start ^ attempt_inc;
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: rtl/vx_ctrl_bus_master.sv
// Host-command initiator for the Vortex control slave's 32-bit generic bus.
// Optional poll timeout is compiled in with VX_CTRL_MASTER_TIMEOUT_EN.
module vx_ctrl_bus_master
  import vx_ctrl_pkg::*;
#(
  parameter int POLL_INTERVAL = 4,
  parameter int MAX_POLLS     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] cmd_mask,
  input  logic [3:0]  cmd_byteen,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] bus_addr,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byte_en,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  output logic [2:0]  dbg_state
);

  // Handshakes: a command or response transfers on the rising edge where
  // valid && ready; the offering side holds payload stable until then.

  state_e              state_q, state_d;
  logic                run_q;
  logic                ren_d, wen_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, mask_q, rdata_q;
  logic [BE_W-1:0]     byteen_q;
  logic                err_q;
  logic                cmd_fire, rsp_fire, bus_done, poll_match;
  logic                poll_start, gap_load, gap_done, attempt_inc, timeout_hit;
  op_e                 op;

  assign op         = op_e'(cmd_op);
  assign cmd_ready  = run_q && (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign bus_done   = (bus_ren || bus_wen) && !bus_busy;
  assign poll_match = ((bus_rdata ^ wdata_q) & mask_q) == '0;

  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_byte_en = byteen_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dbg_state   = state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    poll_start  = 1'b0;
    gap_load    = 1'b0;
    attempt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (op)
            OP_READ:  state_d = ST_RD;
            OP_WRITE: state_d = ST_WR;
            OP_POLL: begin
              state_d    = ST_POLL_RD;
              poll_start = 1'b1;
            end
            default:  state_d = ST_RESP;
          endcase
        end
      end
      ST_RD, ST_WR: begin
        if (bus_done) state_d = ST_RESP;
      end
      ST_POLL_RD: begin
        if (bus_done) begin
          attempt_inc = 1'b1;
          // Match wins over timeout on the final attempt.
          if (poll_match || timeout_hit) begin
            state_d = ST_RESP;
          end else if (POLL_INTERVAL == 0) begin
            state_d = ST_POLL_RD;
          end else begin
            state_d  = ST_POLL_GAP;
            gap_load = 1'b1;
          end
        end
      end
      ST_POLL_GAP: begin
        if (gap_done) state_d = ST_POLL_RD;
      end
      ST_RESP: begin
        if (rsp_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ren_d = (state_d == ST_RD) || (state_d == ST_POLL_RD);
    wen_d = (state_d == ST_WR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q    <= 1'b0;
      bus_ren  <= 1'b0;
      bus_wen  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      byteen_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      bus_ren <= ren_d;
      bus_wen <= wen_d;
      if (cmd_fire) begin
        addr_q   <= cmd_addr;
        wdata_q  <= cmd_wdata;
        mask_q   <= cmd_mask;
        byteen_q <= (op == OP_WRITE) ? cmd_byteen : 4'hF;
        rdata_q  <= '0;
        err_q    <= (op == OP_ILLEGAL);
      end
      if (bus_done && (state_q == ST_RD)) begin
        rdata_q <= bus_rdata;
      end
      if (bus_done && (state_q == ST_POLL_RD)) begin
        rdata_q <= bus_rdata;
        err_q   <= !poll_match && timeout_hit;
      end
    end
  end

  vx_ctrl_bus_master_poll_timer #(
    .POLL_INTERVAL(POLL_INTERVAL),
    .MAX_POLLS    (MAX_POLLS)
  ) u_poll_timer (
    .clk        (clk),
    .reset      (reset),
    .start      (poll_start),
    .gap_load   (gap_load),
    .gap_run    (state_q == ST_POLL_GAP),
    .attempt_inc(attempt_inc),
    .gap_done   (gap_done),
    .timeout_hit(timeout_hit)
  );

endmodule

// File: tb/tb_vx_ctrl_bus_master.sv
// Directed bench for vx_ctrl_bus_master with a response scoreboard; covers the
// timeout or endless-poll behaviour depending on VX_CTRL_MASTER_TIMEOUT_EN.
module tb_vx_ctrl_bus_master;

  localparam int POLL_INTERVAL = 4;
  localparam int MAX_POLLS     = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [31:0] cmd_mask = '0;
  logic [3:0]  cmd_byteen = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] bus_addr;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_rdata = '0;
  logic        bus_busy = 1'b0;
  logic [2:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [32:0] exp_q[$];

  vx_ctrl_bus_master #(
    .POLL_INTERVAL(POLL_INTERVAL),
    .MAX_POLLS    (MAX_POLLS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_mask   (cmd_mask),
    .cmd_byteen (cmd_byteen),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus_addr   (bus_addr),
    .bus_ren    (bus_ren),
    .bus_wen    (bus_wen),
    .bus_wdata  (bus_wdata),
    .bus_byte_en(bus_byte_en),
    .bus_rdata  (bus_rdata),
    .bus_busy   (bus_busy),
    .dbg_state  (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each consumed response with the oldest expectation.
  always begin
    @(negedge clk);
    #1;
    if (reset && rsp_valid && rsp_ready) begin
      check("rsp_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_payload", {rsp_err, rsp_rdata}, e);
      end
    end
  end

  // Driver: called at a negedge with the DUT idle; returns at negedge of T+1.
  task automatic send(input logic [1:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] mask,
                      input logic [3:0] be);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_addr   = addr;
    cmd_wdata  = wdata;
    cmd_mask   = mask;
    cmd_byteen = be;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Bus responder for polls; counts reads and checks idle gaps between them.
  task automatic run_poll(input int hit_at, input logic [31:0] miss_val,
                          input logic [31:0] hit_val, input int max_reads,
                          output int reads, output bit got);
    int gap;
    reads = 0;
    gap   = 0;
    got   = 1'b0;
    for (int c = 0; c < 2000 && !got && reads < max_reads; c++) begin
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (bus_ren) begin
          reads++;
          if (reads > 1) check("poll_gap", gap, POLL_INTERVAL);
          gap = 0;
          bus_rdata = (hit_at != 0 && reads >= hit_at) ? hit_val : miss_val;
        end else begin
          gap++;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int reads;
    bit got;
    logic [31:0] rnd;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus_ren, bus_wen, bus_addr, bus_wdata, bus_byte_en,
                            rsp_valid, rsp_err, rsp_rdata, cmd_ready}, 105'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1'b1);

    // Zero-wait write
    send(2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 4'hF);
    exp_q.push_back({1'b0, 32'h0});
    check("wr_wen", {bus_wen, bus_ren, cmd_ready}, 3'b100);
    check("wr_addr", bus_addr, 32'h0000_0010);
    check("wr_data", bus_wdata, 32'hDEAD_BEEF);
    check("wr_be", bus_byte_en, 4'hF);
    @(negedge clk);
    check("wr_rsp_valid", {rsp_valid, bus_wen}, 2'b10);
    @(negedge clk);
    check("wr_ready_after", {cmd_ready, rsp_valid}, 2'b10);

    // Zero-wait read with random data
    rnd = $urandom();
    bus_rdata = rnd;
    send(2'b00, 32'h0000_0020, 32'h0, 32'h0, 4'h0);
    exp_q.push_back({1'b0, rnd});
    check("rd0_ren", {bus_ren, bus_wen, bus_byte_en}, 6'b10_1111);
    @(negedge clk);
    check("rd0_rsp_valid", {rsp_valid, bus_ren}, 2'b10);
    @(negedge clk);

    // Read with 3 busy cycles
    bus_busy  = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    send(2'b00, 32'h0000_0004, 32'h0, 32'h0, 4'h0);
    exp_q.push_back({1'b0, 32'h1});
    for (int i = 0; i < 3; i++) begin
      check("rdb_ren_held", {bus_ren, rsp_valid, bus_byte_en}, 6'b10_1111);
      check("rdb_addr_held", bus_addr, 32'h0000_0004);
      @(negedge clk);
    end
    bus_busy  = 1'b0;
    bus_rdata = 32'h0000_0001;
    check("rdb_ren_last", {bus_ren, rsp_valid}, 2'b10);
    @(negedge clk);
    check("rdb_rsp_valid", {rsp_valid, bus_ren}, 2'b10);
    @(negedge clk);

    // Partial-byte write with random data
    rnd = $urandom();
    send(2'b01, 32'h0000_0030, rnd, 32'h0, 4'h3);
    exp_q.push_back({1'b0, 32'h0});
    check("wr2_data", {bus_wen, bus_wdata, bus_byte_en}, {1'b1, rnd, 4'h3});
    @(negedge clk);
    @(negedge clk);

    // Poll: status 1,1,0 under mask 1
    send(2'b10, 32'h0000_0004, 32'h0, 32'h1, 4'h0);
    exp_q.push_back({1'b0, 32'h0});
    run_poll(3, 32'h1, 32'h0, 1000, reads, got);
    check("poll_got_rsp", got, 1'b1);
    check("poll_reads", reads, 3);
    @(negedge clk);

    // Poll that matches on the first read only through the mask
    send(2'b10, 32'h0000_0008, 32'h0000_00A0, 32'h0000_00F0, 4'h0);
    exp_q.push_back({1'b0, 32'h0000_00A5});
    run_poll(1, 32'h0, 32'h0000_00A5, 1000, reads, got);
    check("pollm_got_rsp", got, 1'b1);
    check("pollm_reads", reads, 1);
    @(negedge clk);

    // Illegal op with response stalled
    rsp_ready = 1'b0;
    send(2'b11, 32'h0000_0040, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      check("ill_hold", {rsp_valid, rsp_err, rsp_rdata, bus_ren, bus_wen, cmd_ready},
            {2'b11, 32'h0, 3'b000});
      @(negedge clk);
    end
    exp_q.push_back({1'b1, 32'h0});
    rsp_ready = 1'b1;
    @(negedge clk);
    check("ill_ready_after", {cmd_ready, rsp_valid}, 2'b10);

`ifdef VX_CTRL_MASTER_TIMEOUT_EN
    // Stuck status times out after MAX_POLLS reads
    send(2'b10, 32'h0000_0004, 32'h0, 32'h1, 4'h0);
    exp_q.push_back({1'b1, 32'h1});
    run_poll(0, 32'h1, 32'h0, 1000, reads, got);
    check("to_got_rsp", got, 1'b1);
    check("to_reads", reads, MAX_POLLS);
    @(negedge clk);
`else
    // Stuck status keeps polling; abort with reset
    send(2'b10, 32'h0000_0004, 32'h0, 32'h1, 4'h0);
    run_poll(0, 32'h1, 32'h0, 100, reads, got);
    check("nto_no_rsp", {got, rsp_valid}, 2'b00);
    check("nto_reads", reads, 100);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
`endif

    // Reset in the middle of a stalled read
    bus_busy = 1'b1;
    send(2'b00, 32'h0000_0008, 32'h0, 32'h0, 4'h0);
    check("mid_ren", bus_ren, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", {bus_ren, bus_wen, bus_addr, bus_wdata, bus_byte_en,
                                rsp_valid, rsp_err, rsp_rdata, cmd_ready}, 105'd0);
    reset    = 1'b1;
    bus_busy = 1'b0;
    @(negedge clk);
    check("mid_after_release", {cmd_ready, rsp_valid, bus_ren}, 3'b100);
    repeat (3) @(negedge clk);
    check("mid_no_stale_rsp", {rsp_valid, bus_ren}, 2'b00);

    // Final report
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
